// File: rtl/avalon_st_sink.sv
// Avalon-ST sink: accepts a fixed-length incrementing stream, buffers the
// beats in a show-ahead FIFO for a local consumer, checks every beat against
// the expected sequence and reports completion.
module avalon_st_sink #(
   parameter int DATA_W    = 8,
   parameter int DEPTH     = 4,
   parameter int EXP_COUNT = 3,
   parameter int EXP_FIRST = 4
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              valid,
   output logic              ready,
   input  logic [DATA_W-1:0] data,
   input  logic              rd_en,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic [7:0]        beat_cnt,
   output logic              done,
   output logic              error
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RECV = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   occ_q, occ_d;
   logic [7:0]         beat_cnt_q, beat_cnt_d;
   logic               error_q, error_d;
   logic               ready_q, ready_d;
   logic               done_q, done_d;
   logic [DATA_W-1:0]  mem_q [DEPTH];

   logic               accept;
   logic               pop;

   // Expected value of beat k, wrapping modulo 2^DATA_W.
   function automatic logic [DATA_W-1:0] exp_beat(input logic [7:0] k);
      logic [DATA_W+7:0] sum;
      sum = (DATA_W+8)'(EXP_FIRST) + (DATA_W+8)'(k);
      return sum[DATA_W-1:0];
   endfunction

   assign accept = valid && ready_q;
   assign pop    = rd_en && (occ_q != '0);

   // Next-state logic: pointers, occupancy, counters, FSM and registered outputs.
   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      occ_d      = occ_q;
      beat_cnt_d = beat_cnt_q;
      error_d    = error_q;

      if (accept) begin
         wr_ptr_d   = wr_ptr_q + PTR_W'(1);
         beat_cnt_d = beat_cnt_q + 8'd1;
         if (data != exp_beat(beat_cnt_q)) begin
            error_d = 1'b1;
         end
      end

      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end

      // Simultaneous accept and pop leaves occupancy unchanged.
      case ({accept, pop})
         2'b10:   occ_d = occ_q + CNT_W'(1);
         2'b01:   occ_d = occ_q - CNT_W'(1);
         default: occ_d = occ_q;
      endcase

      case (state_q)
         IDLE:    state_d = RECV;
         RECV:    if (accept && (beat_cnt_d == 8'(EXP_COUNT))) state_d = DONE;
         DONE:    state_d = DONE;
         default: state_d = IDLE;
      endcase

      // ready and done are registered from the next state so they never
      // depend combinationally on valid or data.
      ready_d = (state_d == RECV) && (occ_d != CNT_W'(DEPTH));
      done_d  = (state_d == DONE);
   end

   // Control state: FSM, pointers, counters and status flags.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         occ_q      <= '0;
         beat_cnt_q <= '0;
         error_q    <= 1'b0;
         ready_q    <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         occ_q      <= occ_d;
         beat_cnt_q <= beat_cnt_d;
         error_q    <= error_d;
         ready_q    <= ready_d;
         done_q     <= done_d;
      end
   end

   // FIFO storage: data only, no reset; validity is tracked by occupancy.
   always_ff @(posedge clk) begin
      if (accept) begin
         mem_q[wr_ptr_q] <= data;
      end
   end

   assign ready    = ready_q;
   assign done     = done_q;
   assign error    = error_q;
   assign beat_cnt = beat_cnt_q;
   assign rd_valid = (occ_q != '0);
   assign rd_data  = (occ_q != '0) ? mem_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_avalon_st_sink.sv
// Bench for avalon_st_sink: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_avalon_st_sink;

   localparam int EXPN  = 3;
   localparam int EXPF  = 4;
   localparam int DEPA  = 4;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;

   // Instance A: default DEPTH=4
   logic       valid = 1'b0, rd_en = 1'b0;
   logic [7:0] data = 8'd0;
   logic       ready, rd_valid, done, error;
   logic [7:0] rd_data, beat_cnt;

   // Instance B: DEPTH=2 for backpressure
   logic       b_valid = 1'b0, b_rd_en = 1'b0;
   logic [7:0] b_data = 8'd0;
   logic       b_ready, b_rd_valid, b_done, b_error;
   logic [7:0] b_rd_data, b_beat_cnt;

   int n_chk = 0;
   int n_pass = 0;

   // Reference model for instance A
   logic [7:0] m_q[$];
   bit         m_idle;
   int         m_cnt;
   bit         m_err;

   avalon_st_sink #(.DATA_W(8), .DEPTH(DEPA), .EXP_COUNT(EXPN), .EXP_FIRST(EXPF)) dut (
      .clk(clk), .resetn(resetn), .valid(valid), .ready(ready), .data(data),
      .rd_en(rd_en), .rd_valid(rd_valid), .rd_data(rd_data),
      .beat_cnt(beat_cnt), .done(done), .error(error)
   );

   avalon_st_sink #(.DATA_W(8), .DEPTH(2), .EXP_COUNT(EXPN), .EXP_FIRST(EXPF)) dut_b (
      .clk(clk), .resetn(resetn), .valid(b_valid), .ready(b_ready), .data(b_data),
      .rd_en(b_rd_en), .rd_valid(b_rd_valid), .rd_data(b_rd_data),
      .beat_cnt(b_beat_cnt), .done(b_done), .error(b_error)
   );

   always #5 clk = ~clk;

   function automatic bit m_ready();
      return !m_idle && (m_cnt < EXPN) && (m_q.size() < DEPA);
   endfunction

   function automatic logic [7:0] m_head();
      return (m_q.size() > 0) ? m_q[0] : 8'd0;
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_idle = 1'b1;
      m_cnt  = 0;
      m_err  = 1'b0;
   endtask

   // One clock edge; the model sees the inputs that were present at the edge.
   task automatic step();
      bit acc, pp;
      logic [7:0] d;
      acc = valid && m_ready();
      pp  = rd_en && (m_q.size() > 0);
      d   = data;
      @(posedge clk);
      if (pp) void'(m_q.pop_front());
      if (acc) begin
         m_q.push_back(d);
         if (d != 8'((EXPF + m_cnt) % 256)) m_err = 1'b1;
         m_cnt++;
      end
      m_idle = 1'b0;
      #1;
   endtask

   task automatic apply_reset();
      resetn  = 1'b0;
      valid   = 1'b0; rd_en = 1'b0; data = 8'd0;
      b_valid = 1'b0; b_rd_en = 1'b0; b_data = 8'd0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      resetn = 1'b1;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      valid = 1'b1; data = 8'd4; rd_en = 1'b1;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         n_chk++;
         if ({ready, rd_valid, rd_data, beat_cnt, done, error} !== 20'd0)
            $display("FAIL reset_outputs: got ready=%b rd_valid=%b rd_data=%0d beat_cnt=%0d done=%b error=%b, want all 0",
                     ready, rd_valid, rd_data, beat_cnt, done, error);
         else n_pass++;
      end
      valid = 1'b0; rd_en = 1'b0;
      resetn = 1'b1;
      #1;
      n_chk++;
      if (ready !== 1'b0) $display("FAIL ready_first_cycle: got %b want 0", ready);
      else n_pass++;
      step();
      n_chk++;
      if (ready !== 1'b1) $display("FAIL ready_second_cycle: got %b want 1", ready);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      apply_reset();
      valid = 1'b1; data = 8'd4;
      step();
      n_chk++;
      if (beat_cnt !== 8'd0 || ready !== 1'b1)
         $display("FAIL b2b_idle_edge: got beat_cnt=%0d ready=%b want 0,1", beat_cnt, ready);
      else n_pass++;
      for (int k = 0; k < 3; k++) begin
         data = 8'(4 + k);
         step();
         n_chk++;
         if (beat_cnt !== 8'(k + 1) || error !== 1'b0)
            $display("FAIL b2b_accept%0d: got beat_cnt=%0d error=%b want %0d,0", k, beat_cnt, error, k + 1);
         else n_pass++;
      end
      valid = 1'b0;
      n_chk++;
      if (done !== 1'b1 || rd_data !== 8'd4 || ready !== 1'b0 || rd_valid !== 1'b1)
         $display("FAIL b2b_final: got done=%b rd_data=%0d ready=%b rd_valid=%b want 1,4,0,1",
                  done, rd_data, ready, rd_valid);
      else n_pass++;
      step();
      n_chk++;
      if (beat_cnt !== 8'd3 || done !== 1'b1)
         $display("FAIL b2b_saturate: got beat_cnt=%0d done=%b want 3,1", beat_cnt, done);
      else n_pass++;
   endtask

   task automatic test_backpressure();
      apply_reset();
      b_valid = 1'b1; b_data = 8'd4;
      step();
      step();
      b_data = 8'd5;
      step();
      n_chk++;
      if (b_ready !== 1'b0 || b_beat_cnt !== 8'd2)
         $display("FAIL bp_full: got ready=%b beat_cnt=%0d want 0,2", b_ready, b_beat_cnt);
      else n_pass++;
      b_data = 8'd6;
      step();
      n_chk++;
      if (b_beat_cnt !== 8'd2 || b_rd_data !== 8'd4)
         $display("FAIL bp_pending: got beat_cnt=%0d rd_data=%0d want 2,4", b_beat_cnt, b_rd_data);
      else n_pass++;
      b_rd_en = 1'b1;
      step();
      b_rd_en = 1'b0;
      n_chk++;
      if (b_ready !== 1'b1 || b_rd_data !== 8'd5)
         $display("FAIL bp_pop: got ready=%b rd_data=%0d want 1,5", b_ready, b_rd_data);
      else n_pass++;
      step();
      b_valid = 1'b0;
      n_chk++;
      if (b_beat_cnt !== 8'd3 || b_done !== 1'b1 || b_error !== 1'b0)
         $display("FAIL bp_accept6: got beat_cnt=%0d done=%b error=%b want 3,1,0", b_beat_cnt, b_done, b_error);
      else n_pass++;
      for (int k = 0; k < 2; k++) begin
         n_chk++;
         if (b_rd_valid !== 1'b1 || b_rd_data !== 8'(5 + k))
            $display("FAIL bp_read%0d: got rd_valid=%b rd_data=%0d want 1,%0d", k, b_rd_valid, b_rd_data, 5 + k);
         else n_pass++;
         b_rd_en = 1'b1;
         step();
      end
      b_rd_en = 1'b0;
      n_chk++;
      if (b_rd_valid !== 1'b0 || b_rd_data !== 8'd0)
         $display("FAIL bp_empty: got rd_valid=%b rd_data=%0d want 0,0", b_rd_valid, b_rd_data);
      else n_pass++;
   endtask

   task automatic test_error();
      logic [7:0] want [3];
      want[0] = 8'd4; want[1] = 8'd7; want[2] = 8'd6;
      apply_reset();
      valid = 1'b1; data = 8'd4;
      step();
      step();
      n_chk++;
      if (error !== 1'b0) $display("FAIL err_before: got %b want 0", error);
      else n_pass++;
      data = 8'd7;
      step();
      n_chk++;
      if (error !== 1'b1) $display("FAIL err_set: got %b want 1", error);
      else n_pass++;
      data = 8'd6;
      step();
      valid = 1'b0;
      n_chk++;
      if (error !== 1'b1 || done !== 1'b1)
         $display("FAIL err_done: got error=%b done=%b want 1,1", error, done);
      else n_pass++;
      rd_en = 1'b1;
      for (int k = 0; k < 3; k++) begin
         n_chk++;
         if (rd_data !== want[k]) $display("FAIL err_fifo%0d: got %0d want %0d", k, rd_data, want[k]);
         else n_pass++;
         step();
      end
      rd_en = 1'b0;
      n_chk++;
      if (error !== 1'b1 || rd_valid !== 1'b0)
         $display("FAIL err_sticky: got error=%b rd_valid=%b want 1,0", error, rd_valid);
      else n_pass++;
   endtask

   task automatic test_fifo_edges();
      apply_reset();
      rd_en = 1'b1;
      step();
      step();
      n_chk++;
      if (rd_valid !== 1'b0 || rd_data !== 8'd0)
         $display("FAIL empty_pop: got rd_valid=%b rd_data=%0d want 0,0", rd_valid, rd_data);
      else n_pass++;
      rd_en = 1'b0; valid = 1'b1; data = 8'd4;
      step();
      n_chk++;
      if (rd_valid !== 1'b1 || rd_data !== 8'd4)
         $display("FAIL latency: got rd_valid=%b rd_data=%0d want 1,4", rd_valid, rd_data);
      else n_pass++;
      rd_en = 1'b1; data = 8'd5;
      step();
      valid = 1'b0; rd_en = 1'b0;
      n_chk++;
      if (rd_valid !== 1'b1 || rd_data !== 8'd5 || beat_cnt !== 8'd2)
         $display("FAIL acc_pop_occ1: got rd_valid=%b rd_data=%0d beat_cnt=%0d want 1,5,2",
                  rd_valid, rd_data, beat_cnt);
      else n_pass++;
   endtask

   task automatic test_reset_midstream();
      apply_reset();
      valid = 1'b1; data = 8'd4;
      step();
      step();
      data = 8'd5;
      step();
      #2;
      resetn = 1'b0;
      #1;
      n_chk++;
      if (beat_cnt !== 8'd0 || rd_valid !== 1'b0 || ready !== 1'b0 || rd_data !== 8'd0)
         $display("FAIL async_clear: got beat_cnt=%0d rd_valid=%b ready=%b rd_data=%0d want 0,0,0,0",
                  beat_cnt, rd_valid, ready, rd_data);
      else n_pass++;
      apply_reset();
      valid = 1'b1; data = 8'd4;
      step();
      for (int k = 0; k < 3; k++) begin
         data = 8'(4 + k);
         step();
      end
      valid = 1'b0;
      n_chk++;
      if (done !== 1'b1 || error !== 1'b0 || rd_data !== 8'd4 || beat_cnt !== 8'd3)
         $display("FAIL rerun: got done=%b error=%b rd_data=%0d beat_cnt=%0d want 1,0,4,3",
                  done, error, rd_data, beat_cnt);
      else n_pass++;
   endtask

   task automatic test_random();
      for (int r = 0; r < 8; r++) begin
         apply_reset();
         for (int c = 0; c < 30; c++) begin
            valid = ($urandom_range(0, 3) != 0);
            rd_en = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 9) == 0) data = 8'($urandom);
            else data = 8'((EXPF + m_cnt) % 256);
            step();
            n_chk++;
            if (ready !== m_ready() || rd_valid !== (m_q.size() > 0) || rd_data !== m_head())
               $display("FAIL rand_fifo r%0d c%0d: got ready=%b rd_valid=%b rd_data=%0d want %b,%b,%0d",
                        r, c, ready, rd_valid, rd_data, m_ready(), (m_q.size() > 0), m_head());
            else n_pass++;
            n_chk++;
            if (beat_cnt !== 8'(m_cnt) || done !== (m_cnt == EXPN) || error !== m_err)
               $display("FAIL rand_status r%0d c%0d: got beat_cnt=%0d done=%b error=%b want %0d,%b,%b",
                        r, c, beat_cnt, done, error, m_cnt, (m_cnt == EXPN), m_err);
            else n_pass++;
         end
      end
      valid = 1'b0; rd_en = 1'b0;
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_backpressure();
      test_error();
      test_fifo_edges();
      test_reset_midstream();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
